full_adder: RTL and testbench

Registered full adder built from a chain of half-adder pairs. It adds two WIDTH-bit operands and a carry-in, and presents the sum and carry-out one clock after the operands are sampled. It is the basic arithmetic leaf cell for datapath blocks that need a clocked add with a predictable one-cycle latency. At WIDTH=1 it is the classic single-bit full adder.

---
 rtl/full_adder.sv | 63 ++++++
 tb/tb_full_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from per-bit half-adder pairs.
// Define FULLADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef FULLADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   c;

    // Per bit: HA1 on the operands, HA2 on the partial sum and incoming carry.
    always_comb begin
        p    = '0;
        g    = '0;
        s    = '0;
        t    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            p[i]   = a[i] ^ b[i];
            g[i]   = a[i] & b[i];
            s[i]   = p[i] ^ c[i];
            t[i]   = p[i] & c[i];
            c[i+1] = g[i] | t[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            sum   <= s;
            carry <= c[WIDTH];
        end
    end

`ifdef FULLADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1, 4 and 8 side by side.
// Build with FULLADDER_OVF_EN defined to also check the ovf outputs.
module tb_full_adder;

    typedef struct {
        longint s;
        bit     c;
        bit     o;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       a1, b1, ci1;
    logic [3:0] a4, b4;
    logic       ci4;
    logic [7:0] a8, b8;
    logic       ci8;
    logic       sum1, carry1, carry4, carry8;
    logic [3:0] sum4;
    logic [7:0] sum8;
`ifdef FULLADDER_OVF_EN
    logic       ovf1, ovf4, ovf8;
`endif

    res_t q1[$];
    res_t q4[$];
    res_t q8[$];
    bit   started;
    int   n_vec;
    int   n_bad;

    logic [3:0] da4 [8] = '{4'hF, 4'hF, 4'h3, 4'h9, 4'h0, 4'h7, 4'h8, 4'hF};
    logic [3:0] db4 [8] = '{4'h0, 4'hF, 4'h4, 4'h9, 4'h0, 4'h1, 4'h8, 4'h1};
    logic       dc4 [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(ci1),
        .sum(sum1), .carry(carry1)
`ifdef FULLADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    full_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(ci4),
        .sum(sum4), .carry(carry4)
`ifdef FULLADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(ci8),
        .sum(sum8), .carry(carry8)
`ifdef FULLADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer addition, unsigned for sum/carry, signed range test for ovf.
    function automatic res_t model(input int w, input longint a, input longint b, input longint ci);
        res_t   r;
        longint tot, sa, sb, st, half;
        half = longint'(1) << (w - 1);
        tot  = a + b + ci;
        r.s  = tot % (longint'(1) << w);
        r.c  = (tot >= (longint'(1) << w));
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        st   = sa + sb + ci;
        r.o  = (st > half - 1) || (st < -half);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic xa1, input logic xb1, input logic xc1,
                         input logic [3:0] xa4, input logic [3:0] xb4, input logic xc4,
                         input logic [7:0] xa8, input logic [7:0] xb8, input logic xc8);
        a1 = xa1; b1 = xb1; ci1 = xc1;
        a4 = xa4; b4 = xb4; ci4 = xc4;
        a8 = xa8; b8 = xb8; ci8 = xc8;
        q1.push_back(model(1, longint'(xa1), longint'(xb1), longint'(xc1)));
        q4.push_back(model(4, longint'(xa4), longint'(xb4), longint'(xc4)));
        q8.push_back(model(8, longint'(xa8), longint'(xb8), longint'(xc8)));
        started = 1'b1;
    endtask

    task automatic drive_rand();
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_w1"}, {63'd0, sum1} | {62'd0, carry1, 1'b0}, 64'd0);
        chk({tag, "_w4"}, {59'd0, carry4, sum4}, 64'd0);
        chk({tag, "_w8"}, {55'd0, carry8, sum8}, 64'd0);
`ifdef FULLADDER_OVF_EN
        chk({tag, "_ovf"}, {61'd0, ovf1, ovf4, ovf8}, 64'd0);
`endif
    endtask

    // Monitor: one result per clock; an edge taken in reset must show zeros.
    initial begin
        res_t e1, e4, e8;
        logic r;
        forever begin
            @(posedge clk);
            r = rst_n;
            #1;
            if (started) begin
                if (q1.size() == 0 || q4.size() == 0 || q8.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    e4 = q4.pop_front();
                    e8 = q8.pop_front();
                    if (!r) begin
                        chk_zero("in_reset");
                    end else begin
                        chk("w1_sum", 64'(sum1), 64'(e1.s));
                        chk("w1_carry", 64'(carry1), 64'(e1.c));
                        chk("w4_sum", 64'(sum4), 64'(e4.s));
                        chk("w4_carry", 64'(carry4), 64'(e4.c));
                        chk("w8_sum", 64'(sum8), 64'(e8.s));
                        chk("w8_carry", 64'(carry8), 64'(e8.c));
`ifdef FULLADDER_OVF_EN
                        chk("w1_ovf", 64'(ovf1), 64'(e1.o));
                        chk("w4_ovf", 64'(ovf4), 64'(e4.o));
                        chk("w8_ovf", 64'(ovf8), 64'(e8.o));
`endif
                    end
                end
            end
        end
    end

    initial begin
        int pulse_at;
        int rst_cnt;
        logic [2:0] k;
        n_vec   = 0;
        n_bad   = 0;
        started = 1'b0;
        rst_n   = 1'b0;
        a1 = 0; b1 = 0; ci1 = 0; a4 = 0; b4 = 0; ci4 = 0; a8 = 0; b8 = 0; ci8 = 0;
        repeat (2) @(posedge clk);
        #3 chk_zero("por");

        // Release between edges with all-zero inputs loaded.
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 4'h0, 0, 8'h00, 8'h00, 0);
        #2 rst_n = 1'b1;

        // WIDTH=1 exhaustive alongside the WIDTH=4 directed corner list.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            k = 3'(i);
            drive(k[2], k[1], k[0], da4[i], db4[i], dc4[i],
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // Async reset with all outputs nonzero.
        @(negedge clk);
        drive(1, 1, 1, 4'hF, 4'hF, 1, 8'hFF, 8'hFF, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        repeat (2) begin
            @(negedge clk);
            drive_rand();
        end
        @(negedge clk);
        drive_rand();
        #2 rst_n = 1'b1;
        #1 chk_zero("pre_reload");

        pulse_at = $urandom_range(2000, 8000);
        rst_cnt  = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            drive_rand();
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) begin
                    #2 rst_n = 1'b1;
                    #1 chk_zero("rand_pre_reload");
                end
            end else if (i == pulse_at) begin
                #3 rst_n = 1'b0;
                #1 chk_zero("rand_async_rst");
                rst_cnt = $urandom_range(1, 3);
            end
        end

        @(posedge clk);
        #3;
        chk("sb_drained", 64'(q1.size() + q4.size() + q8.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
